// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and load/store ports, data first with anti-starvation
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int BW = DATA_WIDTH/8;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       owner_d;
  logic       d_win, if_win, resp_done;
  always_comb begin
    d_win     = d_req_i && !(if_req_i && starve_cnt == 4'(STARVE_LIMIT));
    if_win    = if_req_i && !d_win;
    if_gnt_o  = state == IDLE && if_win;
    d_gnt_o   = state == IDLE && d_win;
    mem_req_o = state == REQ;
    resp_done = (state == REQ && mem_gnt_i && mem_rvalid_i) || (state == RESP && mem_rvalid_i);
    state_nxt = resp_done ? IDLE :
                (state == IDLE && (if_win || d_win)) ? REQ :
                (state == REQ && mem_gnt_i) ? RESP : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      owner_d     <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
    end else begin
      state       <= state_nxt;
      if_rvalid_o <= resp_done && !owner_d;
      d_rvalid_o  <= resp_done && owner_d;
      if (resp_done && !owner_d) if_rdata_o <= mem_rdata_i;
      if (resp_done && owner_d) d_rdata_o <= mem_rdata_i;
      if (d_gnt_o) begin
        owner_d     <= 1'b1;
        mem_we_o    <= d_we_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
        mem_be_o    <= d_be_i;
        starve_cnt  <= !if_req_i ? 4'd0 : (starve_cnt == 4'hf) ? starve_cnt : starve_cnt + 4'd1;
      end else if (if_gnt_o) begin
        owner_d     <= 1'b0;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
        mem_be_o    <= {BW{1'b1}};
        starve_cnt  <= 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant priority, starvation, stalls, back-to-back and reset abort
module tb_mem_arbiter;
  logic        clk, rst_n;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]  d_be_i, mem_be_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  int          total = 0, bad = 0;
  logic [9:0]  got_seq;
  int          ngnt, both;
  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; d_be_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    cyc; cyc; #1;
    chk("rst_ctl", {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, mem_be_o}, '0);
    chk("rst_data", {if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o}, '0);
    cyc; rst_n = 1'b1;
    // single fetch, memory grants at N+1 and answers at N+3
    cyc; if_req_i = 1'b1; if_addr_i = 32'h10; #1 chk("t1_gnt", {if_gnt_o, d_gnt_o}, 2'b10);
    cyc; if_req_i = 1'b0; mem_gnt_i = 1'b1; #1
    chk("t1_memreq", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, {1'b1, 1'b0, 4'hf, 32'h10});
    cyc; mem_gnt_i = 1'b0; #1 chk("t1_wait", mem_req_o, 1'b0);
    cyc; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0051_3093; #1 chk("t1_early", {if_rvalid_o, d_rvalid_o}, 2'b00);
    cyc; mem_rvalid_i = 1'b0; #1 chk("t1_rvalid", {if_rvalid_o, d_rvalid_o, if_rdata_o}, {2'b10, 32'h0051_3093});
    cyc; #1 chk("t1_pulse", {if_rvalid_o, d_rvalid_o}, 2'b00);
    // both ports always requesting, zero-wait memory
    got_seq = '0; ngnt = 0; both = 0;
    for (int i = 0; i < 20; i++) begin
      cyc; if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400;
      mem_gnt_i = mem_req_o; mem_rvalid_i = mem_req_o; mem_rdata_i = 32'h1000 + i;
      #1;
      if (if_gnt_o && d_gnt_o) both++;
      if (if_gnt_o || d_gnt_o) begin
        got_seq = {got_seq[8:0], d_gnt_o};
        ngnt++;
      end
    end
    chk("t2_order", got_seq, 10'b1111011110);
    chk("t2_count", ngnt, 10);
    chk("t2_both", both, 0);
    cyc; if_req_i = 1'b0; d_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; #1
    chk("t2_last", {if_rvalid_o, d_rvalid_o}, 2'b10);
    // store with a 3-cycle memory stall; inputs scrambled after the grant
    cyc; d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011; #1
    chk("t3_gnt", {if_gnt_o, d_gnt_o}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cyc; d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'hFFF; d_wdata_i = '0; d_be_i = '0; #1
      chk("t3_stall", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, {2'b11, 4'b0011, 32'h100, 32'hDEAD_BEEF});
    end
    cyc; mem_gnt_i = 1'b1; #1
    chk("t3_accept", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, {2'b11, 4'b0011, 32'h100, 32'hDEAD_BEEF});
    cyc; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; #1 chk("t3_resp_state", mem_req_o, 1'b0);
    cyc; mem_rvalid_i = 1'b0; #1 chk("t3_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b01);
    cyc; #1 chk("t3_pulse", {if_rvalid_o, d_rvalid_o}, 2'b00);
    // gnt and rvalid together, fetch pending gets granted back-to-back
    cyc; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_be_i = 4'hf; #1 chk("t4_dgnt", {if_gnt_o, d_gnt_o}, 2'b01);
    cyc; d_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h40; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hCAFE_0001; #1 chk("t4_nognt", {if_gnt_o, d_gnt_o}, 2'b00);
    cyc; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; #1
    chk("t4_b2b", {if_gnt_o, d_gnt_o, d_rvalid_o, if_rvalid_o, d_rdata_o}, {4'b1010, 32'hCAFE_0001});
    cyc; if_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1
    chk("t4_ifreq", {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, 32'h40});
    cyc; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; #1
    chk("t4_ifresp", {if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o}, {2'b10, 32'h1234_5678, 32'hCAFE_0001});
    // spurious response in IDLE, then reset during RESP
    cyc; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD; #1;
    cyc; mem_rvalid_i = 1'b0; #1 chk("t5_spur", {if_rvalid_o, d_rvalid_o, if_rdata_o}, {2'b00, 32'h1234_5678});
    cyc; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300; #1 chk("t5_dgnt", d_gnt_o, 1'b1);
    cyc; d_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    cyc; mem_gnt_i = 1'b0; #1 chk("t5_in_resp", mem_req_o, 1'b0);
    rst_n = 1'b0; #1;
    chk("t5_rst_ctl", {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, mem_be_o}, '0);
    chk("t5_rst_data", {if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o}, '0);
    cyc; rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555; #1;
    cyc; mem_rvalid_i = 1'b0; #1 chk("t5_late", {if_rvalid_o, d_rvalid_o}, 2'b00);
    cyc; if_req_i = 1'b1; if_addr_i = 32'h80; #1 chk("t5_ignt", {if_gnt_o, d_gnt_o}, 2'b10);
    cyc; if_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h600D; #1
    chk("t5_memreq", {mem_req_o, mem_addr_o}, {1'b1, 32'h80});
    cyc; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; #1
    chk("t5_ok", {if_rvalid_o, d_rvalid_o, if_rdata_o}, {2'b10, 32'h600D});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-ported memory between two requesters of the 5-stage core: the instruction-fetch port (IF) and the load/store port (D, MEM stage).
- Data has fixed priority over fetch. A starvation counter forces a fetch grant after STARVE_LIMIT consecutive data wins under contention.
- One outstanding memory transaction at a time, tracked by an IDLE/REQ/RESP state machine.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports (multiple of 8)
- STARVE_LIMIT, 4, consecutive contended data grants before fetch is forced; legal range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  DATA_WIDTH  fetch read data
- d_req_i  in  1  data request; held until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  store data
- d_be_i  in  DATA_WIDTH/8  byte enables
- d_gnt_o  out  1  data request accepted (1-cycle pulse)
- d_rvalid_o  out  1  load data / store ack valid (1-cycle pulse)
- d_rdata_o  out  DATA_WIDTH  load data
- mem_req_o  out  1  memory request, held until mem_gnt_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response (reads and writes)
- mem_rdata_i  in  DATA_WIDTH  memory read data

Behaviour:
- Reset: state IDLE, starve_cnt=0, owner=IF. All outputs 0.
- Reset asserted mid-transaction drops the outstanding access; no rvalid is ever produced for it.
- IDLE:
  - Winner = D if d_req_i and not (if_req_i and starve_cnt==STARVE_LIMIT); else IF if if_req_i.
  - Winner's gnt_o is asserted combinationally in that cycle.
  - At the clock edge: latch winner's command (IF: we=0, be=all ones, wdata=0), set owner, go to REQ.
- REQ:
  - mem_req_o=1; mem_* driven from the latch, stable until mem_gnt_i.
  - mem_gnt_i=1 and mem_rvalid_i=0: go to RESP.
  - mem_gnt_i=1 and mem_rvalid_i=1 in the same cycle: response accepted, go to IDLE.
- RESP: mem_req_o=0. On mem_rvalid_i, capture mem_rdata_i and go to IDLE.
- Response:
  - Owner's rvalid_o pulses the cycle after mem_rvalid_i, with rdata_o registered.
  - Non-owner rvalid_o stays 0; rdata_o holds its last value.
  - Stores also produce d_rvalid_o; d_rdata_o is don't-care on stores.
- mem_rvalid_i in IDLE, or in REQ without mem_gnt_i: ignored.
- No gnt in REQ/RESP. A new grant is possible in the IDLE cycle in which rvalid_o pulses (back-to-back).
- Minimum latency: req at cycle N, gnt_o at N, mem_req_o at N+1, zero-wait memory response at N+1, rvalid_o at N+2.
- starve_cnt (4 bits, saturating):
  - +1 on a D grant while if_req_i=1.
  - Cleared on an IF grant, or on a D grant while if_req_i=0.

Test Plan:
- Single fetch, addr 0x0000_0010. Memory grants at N+1, responds at N+3 with 0x0051_3093 -> if_gnt_o@N, mem_req_o@N+1, if_rvalid_o@N+4, if_rdata_o=0x0051_3093, d_rvalid_o stays 0.
- Both request every cycle, zero-wait memory, STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; no cycle with both gnts.
- Store: addr 0x100, wdata 0xDEAD_BEEF, be 0b0011. Memory stalls mem_gnt_i 3 cycles -> mem_* stable during stall, mem_we_o=1, mem_be_o=0b0011, single d_rvalid_o pulse.
- mem_gnt_i and mem_rvalid_i asserted together -> state returns to IDLE next cycle, pending if_req_i granted that cycle.
- Spurious mem_rvalid_i in IDLE -> no rvalid_o. rst_n low during RESP, then the late mem_rvalid_i arrives -> all outputs 0, no rvalid_o, next request is served normally.
